full_feeder1: RTL and testbench
===============================

Name: full_feeder1

Overview:
- Producer side of the fully-connected layer-1 input interface.
- On a start pulse it clears the downstream accumulators, then walks GROUPS feature groups.
- For each group it loads LANES features from the feature buffer into a held register bank and pulses grp_start.
- It then streams NEURONS per-lane weight words, one per cycle, tagged with the neuron index. After the last group it pulses done.

Parameters:
- DW, 16, signed feature/weight width.
- LANES, 3, features consumed in parallel per group.
- GROUPS, 16, feature groups per image.
- NEURONS, 31, weight words per group (neuron index 0..NEURONS-1).
- FAW, 6, feature memory address width (>= clog2(GROUPS*LANES)).
- WAW, 9, weight memory address width (>= clog2(GROUPS*NEURONS)).

Ports:
- clk, in, 1, clock.
- n_reset, in, 1, reset: n_reset, asynchronous, active-low; clock clk.
- start, in, 1, one-cycle request to process one image.
- cons_busy, in, 1, consumer still accumulating the previous group.
- feat_addr, out, FAW, feature memory read address.
- feat_rdata, in, DW, feature memory data, valid 1 cycle after feat_addr (synchronous read).
- wgt_addr, out, WAW, weight memory read address.
- wgt_rdata, in, LANES*DW, per-lane weights for one neuron; lane 0 in LSBs; 1-cycle read latency.
- clear_out, out, 1, one-cycle accumulator clear.
- feat_out, out, LANES*DW, held features of the current group; lane 0 in LSBs.
- grp_start, out, 1, one-cycle pulse: feat_out is valid and the weight stream follows.
- wgt_out, out, LANES*DW, weight word for wgt_idx.
- wgt_valid, out, 1, wgt_out/wgt_idx valid this cycle.
- wgt_idx, out, 5, neuron index of wgt_out.
- grp_idx, out, 4, current group index.
- busy, out, 1, high from start acceptance until done.
- done, out, 1, one-cycle pulse after the last weight of the last group.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; feat_out bank = 0; counters = 0.
- IDLE: start=1 -> CLEAR; busy rises the next cycle. start while busy=1 is ignored and not queued.
- CLEAR (1 cycle): clear_out=1; g<=0 -> LOAD.
- LOAD: issue feat_addr = g*LANES+l for l = 0..LANES-1 on consecutive cycles. feat_rdata captured into lane l one cycle later. After the lane LANES-1 capture -> WAIT (LANES+1 cycles total). Features are updated only here.
- WAIT: remain while cons_busy=1; when cons_busy=0 -> START.
- START (1 cycle): grp_start=1.
  - Issue wgt_addr = g*NEURONS+0 in the same cycle.
  - grp_idx = g.
  - -> STREAM.
- STREAM:
  - Issue addresses n=1..NEURONS-1 on consecutive cycles.
  - wgt_valid=1 exactly NEURONS consecutive cycles, starting the cycle after START. wgt_out = wgt_rdata, wgt_idx = n.
  - First valid beat therefore arrives one cycle after grp_start, with no gaps.
  - After the beat with wgt_idx = NEURONS-1: if g = GROUPS-1 -> DONE, else g<=g+1 -> LOAD.
- The next group's LOAD begins the cycle after its predecessor's last beat. feat_out changes only after that last beat, so the consumer always sees stable features for a whole group.
- DONE (1 cycle): done=1; busy falls the same cycle done is asserted -> IDLE.
- cons_busy is ignored outside WAIT.
- Outputs when not active: wgt_out/wgt_idx = 0 when wgt_valid=0. feat_addr/wgt_addr hold their last value when idle.
- Latency: start to first grp_start = 1 (CLEAR) + LANES+1 (LOAD) + 1 = 6 cycles for LANES=3 and cons_busy=0.
- Per-group period with cons_busy=0: (LANES+1) + 1 + NEURONS = 36 cycles.
- Total start to done = 2 + GROUPS*36 = 578 cycles.
- Counter wrap: g and n use exact-compare terminal counts (GROUPS-1, NEURONS-1). No power-of-2 wrap is relied upon.
- Reset mid-operation: immediate return to IDLE, all outputs 0. No done pulse; the consumer must also be reset.
- No arithmetic is done on data; values pass through bit-exact and signed.

Test Plan:
- Single image:
  - Stimulus: feature mem[i] = i+1, weight word w = {w*3+2, w*3+1, w*3} (lane2, lane1, lane0); start pulse, cons_busy=0.
  - Required: clear_out at cycle 1. First grp_start at cycle 6 with feat_out lanes {3,2,1}.
  - Required: 31 contiguous wgt_valid beats, wgt_idx 0..30, first beat lanes {2,1,0}.
  - Required: group 15 feat_out lanes {48,47,46}; done at cycle 578.
- Backpressure:
  - Stimulus: hold cons_busy=1 for 10 cycles after the first group's last beat.
  - Required: grp_start for group 1 delayed exactly 10 cycles. feat_out stable during the stall. No wgt_valid while stalled.
- Start while busy: pulse start at cycles 50 and 300 -> ignored; exactly one clear_out and one done.
- Reset mid-stream: assert n_reset low during group 5, wgt_idx=12 -> all outputs 0 the same edge. Re-start then produces a full 578-cycle run beginning at group 0.
- Signed pass-through: features -32768 and 32767, weights 16'h8000 -> appear bit-exact on feat_out and wgt_out.
- Back-to-back images: start the cycle after done -> second clear_out 1 cycle later; identical beat sequence to the first image.

Source files
------------

// File: rtl/full_feeder1_if.sv
// Bus bundle between the layer-1 feeder, its feature/weight memories and the FC consumer.
// The master modport is the feeder; the slave modport is everything around it.
interface full_feeder1_if #(
  parameter int unsigned DW    = 16,
  parameter int unsigned LANES = 3,
  parameter int unsigned FAW   = 6,
  parameter int unsigned WAW   = 9
);
  logic                  start;
  logic                  cons_busy;
  logic [FAW-1:0]        feat_addr;
  logic [DW-1:0]         feat_rdata;
  logic [WAW-1:0]        wgt_addr;
  logic [LANES*DW-1:0]   wgt_rdata;
  logic                  clear_out;
  logic [LANES*DW-1:0]   feat_out;
  logic                  grp_start;
  logic [LANES*DW-1:0]   wgt_out;
  logic                  wgt_valid;
  logic [4:0]            wgt_idx;
  logic [3:0]            grp_idx;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, cons_busy, feat_rdata, wgt_rdata,
    output feat_addr, wgt_addr, clear_out, feat_out, grp_start, wgt_out, wgt_valid,
           wgt_idx, grp_idx, busy, done
  );

  modport slave (
    output start, cons_busy, feat_rdata, wgt_rdata,
    input  feat_addr, wgt_addr, clear_out, feat_out, grp_start, wgt_out, wgt_valid,
           wgt_idx, grp_idx, busy, done
  );
endinterface

// File: rtl/full_feeder1.sv
// Layer-1 FC feeder: per group, loads LANES features into a held bank, then streams
// NEURONS per-lane weight words tagged with their neuron index.
module full_feeder1 #(
  parameter int unsigned DW      = 16,
  parameter int unsigned LANES   = 3,
  parameter int unsigned GROUPS  = 16,
  parameter int unsigned NEURONS = 31,
  parameter int unsigned FAW     = 6,
  parameter int unsigned WAW     = 9
) (
  input  logic           clk,
  input  logic           n_reset,
  full_feeder1_if.master ff
);

  localparam int unsigned      LW       = $clog2(LANES + 1);
  localparam logic [LW-1:0]    LastLane = LW'(LANES);
  localparam logic [4:0]       LastN    = 5'(NEURONS - 1);
  localparam logic [3:0]       LastG    = 4'(GROUPS - 1);

  typedef enum logic [2:0] {StIdle, StClear, StLoad, StWait, StStream, StDone} state_e;

  state_e               r_state, w_state;
  logic [3:0]           r_g;
  logic [LW-1:0]        r_lane;
  logic [4:0]           r_n;
  logic [LANES*DW-1:0]  r_feat;
  logic [FAW-1:0]       r_feat_addr;
  logic [WAW-1:0]       r_wgt_addr;

  logic                 w_clear, w_grp_start, w_valid, w_done;
  logic                 w_feat_issue, w_wgt_issue;
  logic [4:0]           w_n_issue;
  logic [FAW-1:0]       w_feat_addr;
  logic [WAW-1:0]       w_wgt_addr;

  // The group-start cycle is the released WAIT cycle, so an unstalled group costs no
  // extra cycle between the last feature capture and grp_start.
  always_comb begin
    w_state      = r_state;
    w_clear      = 1'b0;
    w_grp_start  = 1'b0;
    w_valid      = 1'b0;
    w_done       = 1'b0;
    w_feat_issue = 1'b0;
    w_wgt_issue  = 1'b0;
    w_n_issue    = '0;
    case (r_state)
      StIdle:  if (ff.start) w_state = StClear;
      StClear: begin
        w_clear = 1'b1;
        w_state = StLoad;
      end
      StLoad: begin
        w_feat_issue = (r_lane != LastLane);
        if (r_lane == LastLane) w_state = StWait;
      end
      StWait: begin
        if (!ff.cons_busy) begin
          w_grp_start = 1'b1;
          w_wgt_issue = 1'b1;
          w_state     = StStream;
        end
      end
      StStream: begin
        w_valid = 1'b1;
        if (r_n == LastN) begin
          w_state = (r_g == LastG) ? StDone : StLoad;
        end else begin
          w_wgt_issue = 1'b1;
          w_n_issue   = r_n + 5'd1;
        end
      end
      StDone: begin
        w_done  = 1'b1;
        w_state = StIdle;
      end
      default: w_state = StIdle;
    endcase
  end

  assign w_feat_addr = FAW'(32'(r_g) * LANES + 32'(r_lane));
  assign w_wgt_addr  = WAW'(32'(r_g) * NEURONS + 32'(w_n_issue));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= StIdle;
      r_g         <= '0;
      r_lane      <= '0;
      r_n         <= '0;
      r_feat      <= '0;
      r_feat_addr <= '0;
      r_wgt_addr  <= '0;
    end else begin
      r_state <= w_state;
      if (w_feat_issue) r_feat_addr <= w_feat_addr;
      if (w_wgt_issue)  r_wgt_addr  <= w_wgt_addr;
      case (r_state)
        StClear: begin
          r_g    <= '0;
          r_lane <= '0;
        end
        StLoad: begin
          // Read data for lane l returns while lane l+1 is being addressed.
          for (int l = 0; l < LANES; l++) begin
            if (r_lane == LW'(l + 1)) r_feat[l*DW +: DW] <= ff.feat_rdata;
          end
          r_lane <= (r_lane == LastLane) ? '0 : r_lane + 1'b1;
        end
        StWait: if (!ff.cons_busy) r_n <= '0;
        StStream: begin
          if (r_n == LastN) begin
            r_n <= '0;
            if (r_g != LastG) r_g <= r_g + 4'd1;
          end else begin
            r_n <= r_n + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Addresses hold their last issued value whenever nothing is being read.
  assign ff.feat_addr = w_feat_issue ? w_feat_addr : r_feat_addr;
  assign ff.wgt_addr  = w_wgt_issue ? w_wgt_addr : r_wgt_addr;
  assign ff.clear_out = w_clear;
  assign ff.grp_start = w_grp_start;
  assign ff.feat_out  = r_feat;
  assign ff.wgt_valid = w_valid;
  assign ff.wgt_out   = w_valid ? ff.wgt_rdata : '0;
  assign ff.wgt_idx   = w_valid ? r_n : '0;
  assign ff.grp_idx   = r_g;
  assign ff.busy      = (r_state != StIdle) && (r_state != StDone);
  assign ff.done      = w_done;

endmodule

// File: tb/tb_full_feeder1.sv
// Bench for full_feeder1: memory models, a vector table of whole-image runs checked
// through a grp_start/beat scoreboard, plus reset-state and mid-stream reset sequences.
module tb_full_feeder1;
  localparam int unsigned DW      = 16;
  localparam int unsigned LANES   = 3;
  localparam int unsigned GROUPS  = 16;
  localparam int unsigned NEURONS = 31;
  localparam int unsigned FAW     = 6;
  localparam int unsigned WAW     = 9;
  localparam int unsigned WW      = LANES * DW;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  full_feeder1_if #(.DW(DW), .LANES(LANES), .FAW(FAW), .WAW(WAW)) ff ();

  full_feeder1 #(
    .DW(DW), .LANES(LANES), .GROUPS(GROUPS), .NEURONS(NEURONS), .FAW(FAW), .WAW(WAW)
  ) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .ff     (ff)
  );

  logic [DW-1:0] fmem [2**FAW];
  logic [WW-1:0] wmem [2**WAW];

  always @(posedge clk) begin
    ff.feat_rdata <= fmem[ff.feat_addr];
    ff.wgt_rdata  <= wmem[ff.wgt_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int rel; int g; logic [WW-1:0] feat;} grp_t;
  typedef struct {int rel; int g; int idx; logic [WW-1:0] word;} beat_t;
  typedef struct {int pat; int stall; int xs1; int xs2; int exp_done;} vec_t;

  grp_t  exp_grp[$];
  beat_t exp_beat[$];
  vec_t  vecs[4];

  int n_chk = 0, n_fail = 0;
  int t0 = 0, cur_done = 0, clr_cnt = 0, done_cnt = 0;
  logic mon_en = 1'b0;
  logic [WW-1:0] cur_feat = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] f_feat(input int pat, input int i);
    if (pat == 0) return 16'(i + 1);
    return (i % 2 == 1) ? 16'h7fff : 16'h8000;
  endfunction

  function automatic logic [WW-1:0] f_wgt(input int pat, input int w);
    if (pat == 0) return {16'(w * 3 + 2), 16'(w * 3 + 1), 16'(w * 3)};
    return {16'h8000, 16'(w), 16'h8000};
  endfunction

  // Fill memories, queue the expected group/beat sequence, and raise start.
  task automatic launch(input int pat, input int stall);
    int grel;
    for (int i = 0; i < 2**FAW; i++) fmem[i] = f_feat(pat, i);
    for (int w = 0; w < 2**WAW; w++) wmem[w] = f_wgt(pat, w);
    for (int g = 0; g < GROUPS; g++) begin
      grel = 6 + 36 * g + ((g > 0) ? stall : 0);
      exp_grp.push_back('{grel, g, {f_feat(pat, g*3 + 2), f_feat(pat, g*3 + 1),
                                    f_feat(pat, g*3)}});
      for (int n = 0; n < NEURONS; n++)
        exp_beat.push_back('{grel + 1 + n, g, n, f_wgt(pat, g * NEURONS + n)});
    end
    clr_cnt  = 0;
    done_cnt = 0;
    ff.start = 1'b1;
    t0       = cyc;
  endtask

  task automatic run_image(input vec_t v);
    int rel;
    launch(v.pat, v.stall);
    cur_done = v.exp_done;
    forever begin
      @(negedge clk);
      rel = cyc - t0;
      if (done_cnt > 0) begin
        ff.start     = 1'b0;
        ff.cons_busy = 1'b0;
        break;
      end
      if (rel > v.exp_done + 20) begin
        chk("done_timeout", 64'(0), 64'(1));
        ff.start     = 1'b0;
        ff.cons_busy = 1'b0;
        break;
      end
      ff.start     = (rel == v.xs1) || (rel == v.xs2);
      ff.cons_busy = (rel >= 42) && (rel < 42 + v.stall);
    end
    chk("clear_count", 64'(clr_cnt), 64'(1));
    chk("done_count", 64'(done_cnt), 64'(1));
    chk("grp_left", 64'(exp_grp.size()), 64'(0));
    chk("beat_left", 64'(exp_beat.size()), 64'(0));
    exp_grp.delete();
    exp_beat.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_clear"}, 64'(ff.clear_out), 64'(0));
    chk({tag, "_grp_start"}, 64'(ff.grp_start), 64'(0));
    chk({tag, "_wgt_valid"}, 64'(ff.wgt_valid), 64'(0));
    chk({tag, "_wgt_idx"}, 64'(ff.wgt_idx), 64'(0));
    chk({tag, "_wgt_out"}, 64'(ff.wgt_out), 64'(0));
    chk({tag, "_grp_idx"}, 64'(ff.grp_idx), 64'(0));
    chk({tag, "_busy"}, 64'(ff.busy), 64'(0));
    chk({tag, "_done"}, 64'(ff.done), 64'(0));
    chk({tag, "_feat_out"}, 64'(ff.feat_out), 64'(0));
    chk({tag, "_feat_addr"}, 64'(ff.feat_addr), 64'(0));
    chk({tag, "_wgt_addr"}, 64'(ff.wgt_addr), 64'(0));
  endtask

  // Monitor samples just after the falling edge, once the driver's inputs have settled.
  always @(negedge clk) begin
    int    rel;
    grp_t  eg;
    beat_t eb;
    #1;
    if (mon_en) begin
      rel = cyc - t0;
      if (ff.clear_out) begin
        clr_cnt++;
        chk("clear_rel", 64'(rel), 64'(1));
        chk("busy_at_clear", 64'(ff.busy), 64'(1));
      end
      if (ff.cons_busy && exp_grp.size() > 0)
        chk("stall_feat", 64'(ff.feat_out), 64'(exp_grp[0].feat));
      if (ff.grp_start) begin
        if (exp_grp.size() == 0) chk("grp_unexpected", 64'(1), 64'(0));
        else begin
          eg = exp_grp.pop_front();
          chk("grp_rel", 64'(rel), 64'(eg.rel));
          chk("grp_idx", 64'(ff.grp_idx), 64'(eg.g));
          chk("grp_feat", 64'(ff.feat_out), 64'(eg.feat));
          cur_feat = eg.feat;
        end
      end
      if (ff.wgt_valid) begin
        if (exp_beat.size() == 0) chk("beat_unexpected", 64'(1), 64'(0));
        else begin
          eb = exp_beat.pop_front();
          chk("beat_rel", 64'(rel), 64'(eb.rel));
          chk("beat_idx", 64'(ff.wgt_idx), 64'(eb.idx));
          chk("beat_grp", 64'(ff.grp_idx), 64'(eb.g));
          chk("beat_word", 64'(ff.wgt_out), 64'(eb.word));
          chk("beat_feat", 64'(ff.feat_out), 64'(cur_feat));
        end
      end else begin
        chk("idle_zero", 64'({ff.wgt_idx, ff.wgt_out}), 64'(0));
      end
      if (ff.done) begin
        done_cnt++;
        chk("done_rel", 64'(rel), 64'(cur_done));
        chk("busy_at_done", 64'(ff.busy), 64'(0));
      end
    end
  end

  initial begin
    // pat, stall cycles in group-1 WAIT, ignored start offsets, expected done cycle
    vecs[0] = '{0, 0, -1, -1, 578};
    vecs[1] = '{0, 10, -1, -1, 588};
    vecs[2] = '{0, 0, 50, 300, 578};
    vecs[3] = '{1, 0, -1, -1, 578};

    n_reset      = 1'b0;
    ff.start     = 1'b0;
    ff.cons_busy = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    n_reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Each vector starts the cycle after the previous done: back-to-back images.
    for (int v = 0; v < 4; v++) run_image(vecs[v]);

    // Mid-stream reset at group 5, beat 12 (cycle 6 + 5*36 + 1 + 12 = 199).
    launch(0, 0);
    cur_done = 578;
    repeat (199) begin
      @(negedge clk);
      ff.start = 1'b0;
    end
    #2;
    chk("pre_rst_idx", 64'(ff.wgt_idx), 64'(12));
    chk("pre_rst_grp", 64'(ff.grp_idx), 64'(5));
    n_reset = 1'b0;
    #1;
    check_all_zero("mid_rst");
    exp_grp.delete();
    exp_beat.delete();
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    run_image(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
